// File: rtl/hash_target_check_if.sv
// Handshake and result bundle between the mining FSM and hash_target_check.
// The master drives the digest strobe and control; the slave returns status.
interface hash_target_check_if;
   logic         hash_valid;
   logic [255:0] HASH;
   logic [31:0]  nonce_in;
   logic [255:0] target_in;
   logic         target_load;
   logic         clear;
   logic         busy;
   logic         result_valid;
   logic         hit;
   logic         stop;
   logic [31:0]  found_nonce;
   logic [255:0] found_hash;
   logic         overrun;
   logic [31:0]  attempts;
   logic [1:0]   state_dbg;

   modport master (
      output hash_valid, HASH, nonce_in, target_in, target_load, clear,
      input  busy, result_valid, hit, stop, found_nonce, found_hash,
             overrun, attempts, state_dbg
   );

   modport slave (
      input  hash_valid, HASH, nonce_in, target_in, target_load, clear,
      output busy, result_valid, hit, stop, found_nonce, found_hash,
             overrun, attempts, state_dbg
   );
endinterface

// File: rtl/hash_target_check.sv
// Serial 32-bit-per-cycle HASH <= target comparator, MS word first, latching the first winner.
// Optional attempt counter is built only when HTC_ATTEMPT_COUNTER_EN is defined.
//
// Handshake: hash_valid is a one-cycle strobe accepted only in IDLE; result_valid is a
// one-cycle pulse, hit qualifies it; stop holds high in FOUND until clear or reset.
module hash_target_check #(
   parameter logic [255:0] TGT_RESET = {32'h0000_0000, 32'hFFFF_0000, 192'h0}
) (
   input logic              clock,
   input logic              reset,
   hash_target_check_if.slave bus
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_CMP   = 2'd1,
      S_FOUND = 2'd2
   } state_t;

   state_t       state;
   logic [255:0] target_q;
   logic [255:0] hash_q;
   logic [31:0]  nonce_q;
   logic [2:0]   idx;
   logic         busy_q;
   logic         result_valid_q;
   logic         hit_q;
   logic         stop_q;
   logic         overrun_q;
   logic [31:0]  found_nonce_q;
   logic [255:0] found_hash_q;

   // Word idx sits at bit offset (7 - idx) * 32, i.e. {~idx, 5'b0}.
   logic [7:0]   word_lo;
   logic [31:0]  h_w;
   logic [31:0]  t_w;

   assign word_lo = {~idx, 5'd0};
   assign h_w     = hash_q[word_lo +: 32];
   assign t_w     = target_q[word_lo +: 32];

   always_ff @(posedge clock) begin
      if (!reset) begin
         state          <= S_IDLE;
         target_q       <= TGT_RESET;
         hash_q         <= '0;
         nonce_q        <= '0;
         idx            <= '0;
         busy_q         <= 1'b0;
         result_valid_q <= 1'b0;
         hit_q          <= 1'b0;
         stop_q         <= 1'b0;
         overrun_q      <= 1'b0;
         found_nonce_q  <= '0;
         found_hash_q   <= '0;
      end else begin
         result_valid_q <= 1'b0;
         hit_q          <= 1'b0;
         if (bus.clear) begin
            state         <= S_IDLE;
            idx           <= '0;
            busy_q        <= 1'b0;
            stop_q        <= 1'b0;
            overrun_q     <= 1'b0;
            found_nonce_q <= '0;
            found_hash_q  <= '0;
         end else begin
            case (state)
               S_IDLE: begin
                  // A same-cycle load is in target_q before the first word is compared.
                  if (bus.target_load) target_q <= bus.target_in;
                  if (bus.hash_valid) begin
                     hash_q  <= bus.HASH;
                     nonce_q <= bus.nonce_in;
                     idx     <= '0;
                     busy_q  <= 1'b1;
                     state   <= S_CMP;
                  end
               end
               S_CMP: begin
                  if (bus.hash_valid) overrun_q <= 1'b1;
                  if (h_w < t_w || (h_w == t_w && idx == 3'd7)) begin
                     state          <= S_FOUND;
                     idx            <= '0;
                     busy_q         <= 1'b0;
                     stop_q         <= 1'b1;
                     result_valid_q <= 1'b1;
                     hit_q          <= 1'b1;
                     found_nonce_q  <= nonce_q;
                     found_hash_q   <= hash_q;
                  end else if (h_w > t_w) begin
                     state          <= S_IDLE;
                     idx            <= '0;
                     busy_q         <= 1'b0;
                     result_valid_q <= 1'b1;
                  end else begin
                     idx <= idx + 3'd1;
                  end
               end
               S_FOUND: begin
                  state <= S_FOUND;
               end
               default: begin
                  state <= S_IDLE;
               end
            endcase
         end
      end
   end

`ifdef HTC_ATTEMPT_COUNTER_EN
   logic [31:0] attempts_q;

   always_ff @(posedge clock) begin
      if (!reset) begin
         attempts_q <= '0;
      end else if (bus.clear) begin
         attempts_q <= '0;
      end else if (state == S_IDLE && bus.hash_valid && attempts_q != 32'hFFFF_FFFF) begin
         attempts_q <= attempts_q + 32'd1;
      end
   end

   assign bus.attempts = attempts_q;
`else
   assign bus.attempts = 32'h0;
`endif

   assign bus.busy         = busy_q;
   assign bus.result_valid = result_valid_q;
   assign bus.hit          = hit_q;
   assign bus.stop         = stop_q;
   assign bus.overrun      = overrun_q;
   assign bus.found_nonce  = found_nonce_q;
   assign bus.found_hash   = found_hash_q;
   assign bus.state_dbg    = state;

endmodule
